// File: rtl/vfpu_package.sv
// Shared types and constants for the vfpu stream ALU.
// Lane width is fixed; stream width is a multiple of it.
package vfpu_package;

    localparam int unsigned VFPU_LANE_W = 32;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        MIN = 3'd3,
        MAX = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } vfpu_state_t;

endpackage

// File: rtl/vfpu_lane_alu.sv
// One 32-bit lane of the stream ALU; purely combinational.
// MIN/MAX compare signed, everything else is modulo 2^32.
module vfpu_lane_alu
    import vfpu_package::*;
(
    input  alu_op_t                op,
    input  logic [VFPU_LANE_W-1:0] a,
    input  logic [VFPU_LANE_W-1:0] b,
    output logic [VFPU_LANE_W-1:0] res
);

    always_comb begin
        res = '0;
        case (op)
            ADD:     res = a + b;
            SUB:     res = a - b;
            MUL:     res = a * b;
            MIN:     res = ($signed(a) < $signed(b)) ? a : b;
            MAX:     res = ($signed(a) > $signed(b)) ? a : b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/vfpu_stream_alu.sv
// Joins two operand streams, applies a per-lane op and pipelines the result
// over PIPE_STAGES elastic registers; runs a job of len_i beats.
module vfpu_stream_alu
    import vfpu_package::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  alu_op_t                 op_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [DATA_WIDTH-1:0]   a_data_i,
    input  logic [DATA_WIDTH/8-1:0] a_strb_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [DATA_WIDTH-1:0]   b_data_i,
    input  logic [DATA_WIDTH/8-1:0] b_strb_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [DATA_WIDTH/8-1:0] r_strb_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [LEN_WIDTH-1:0]    cnt_o
);

    localparam int unsigned NB_LANES = DATA_WIDTH / VFPU_LANE_W;
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;

    vfpu_state_t          state;
    alu_op_t              op_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;

    logic [PIPE_STAGES-1:0] stg_valid;
    logic [PIPE_STAGES-1:0] stg_ready;
    logic [DATA_WIDTH-1:0]  stg_data [PIPE_STAGES];
    logic [STRB_W-1:0]      stg_strb [PIPE_STAGES];

    logic [DATA_WIDTH-1:0] alu_res;
    logic                  run;
    logic                  fire;
    logic                  last_beat;

    for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
        vfpu_lane_alu u_lane_alu (
            .op  (op_q),
            .a   (a_data_i[i*VFPU_LANE_W +: VFPU_LANE_W]),
            .b   (b_data_i[i*VFPU_LANE_W +: VFPU_LANE_W]),
            .res (alu_res[i*VFPU_LANE_W +: VFPU_LANE_W])
        );
    end

    // Each operand's ready looks only at the other's valid, so neither side is consumed alone.
    assign run       = (state == RUN);
    assign a_ready_o = run & b_valid_i & stg_ready[0];
    assign b_ready_o = run & a_valid_i & stg_ready[0];
    assign fire      = run & a_valid_i & b_valid_i & stg_ready[0];
    assign last_beat = fire & ((cnt_q + LEN_WIDTH'(1)) == len_q);

    // ready[k] = ~valid[k] | ready[k+1], unrolled from the sink backwards into an
    // accumulated "everything downstream is full" term to avoid a self-referencing vector.
    always_comb begin
        logic all_full;
        all_full  = 1'b1;
        stg_ready = '0;
        for (int unsigned j = 0; j < PIPE_STAGES; j++) begin
            all_full = all_full & stg_valid[PIPE_STAGES-1-j];
            stg_ready[PIPE_STAGES-1-j] = r_ready_i | ~all_full;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stg_valid <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                stg_data[k] <= '0;
                stg_strb[k] <= '0;
            end
        end else if (clear_i) begin
            stg_valid <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                stg_data[k] <= '0;
                stg_strb[k] <= '0;
            end
        end else begin
            if (stg_ready[0]) begin
                stg_valid[0] <= fire;
                stg_data[0]  <= alu_res;
                stg_strb[0]  <= a_strb_i & b_strb_i;
            end
            for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
                if (stg_ready[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    stg_data[k]  <= stg_data[k-1];
                    stg_strb[k]  <= stg_strb[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            op_q   <= ADD;
            len_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (clear_i) begin
            state  <= IDLE;
            op_q   <= ADD;
            len_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        len_q <= len_i;
                        cnt_q <= '0;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire && (cnt_q != len_q)) begin
                        cnt_q <= cnt_q + LEN_WIDTH'(1);
                    end
                    if (last_beat) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (stg_valid == '0) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign r_valid_o = stg_valid[PIPE_STAGES-1];
    assign r_data_o  = stg_data[PIPE_STAGES-1];
    assign r_strb_o  = stg_strb[PIPE_STAGES-1];
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_vfpu_stream_alu.sv
// Randomised bench for vfpu_stream_alu (64-bit, two stages) against a
// lane-wise arithmetic reference model and an in-order result queue.
module tb_vfpu_stream_alu;
    import vfpu_package::*;

    localparam int unsigned DW = 64;
    localparam int unsigned PS = 2;
    localparam int unsigned LW = 16;
    localparam int unsigned SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          start_i;
    alu_op_t       op_i;
    logic [LW-1:0] len_i;
    logic          a_valid_i;
    logic          a_ready_o;
    logic [DW-1:0] a_data_i;
    logic [SW-1:0] a_strb_i;
    logic          b_valid_i;
    logic          b_ready_o;
    logic [DW-1:0] b_data_i;
    logic [SW-1:0] b_strb_i;
    logic          r_valid_o;
    logic          r_ready_i;
    logic [DW-1:0] r_data_o;
    logic [SW-1:0] r_strb_o;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] cnt_o;

    vfpu_stream_alu #(
        .DATA_WIDTH  (DW),
        .PIPE_STAGES (PS),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .len_i     (len_i),
        .a_valid_i (a_valid_i),
        .a_ready_o (a_ready_o),
        .a_data_i  (a_data_i),
        .a_strb_i  (a_strb_i),
        .b_valid_i (b_valid_i),
        .b_ready_o (b_ready_o),
        .b_data_i  (b_data_i),
        .b_strb_i  (b_strb_i),
        .r_valid_o (r_valid_o),
        .r_ready_i (r_ready_i),
        .r_data_o  (r_data_o),
        .r_strb_o  (r_strb_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .cnt_o     (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_d [$];
    logic [SW-1:0] exp_s [$];
    logic [DW-1:0] ja  [16];
    logic [DW-1:0] jb  [16];
    logic [SW-1:0] jsa [16];
    logic [SW-1:0] jsb [16];

    int              fires = 0;
    int              dones = 0;
    int              ready_cycles = 0;
    logic [LW-1:0]   cnt_at_done = '0;
    logic            hold_pend = 1'b0;
    logic [DW+SW:0]  held = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_lanes(input alu_op_t op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < int'(DW / 32); l++) begin
            longint unsigned x, y, v;
            int sx, sy;
            x  = {32'b0, a[l*32 +: 32]};
            y  = {32'b0, b[l*32 +: 32]};
            sx = $signed(a[l*32 +: 32]);
            sy = $signed(b[l*32 +: 32]);
            case (op)
                ADD:     v = (x + y) % 64'h1_0000_0000;
                SUB:     v = (x + 64'h1_0000_0000 - y) % 64'h1_0000_0000;
                MUL:     v = (x * y) % 64'h1_0000_0000;
                MIN:     v = (sx < sy) ? x : y;
                MAX:     v = (sx > sy) ? x : y;
                default: v = 0;
            endcase
            r[l*32 +: 32] = v[31:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [127:0] outs_vec();
        return 128'({a_ready_o, b_ready_o, r_valid_o, r_data_o, r_strb_o, busy_o, done_o, cnt_o});
    endfunction

    // Output monitor: scoreboard pop on result handshake plus hold-stability under stall.
    always @(negedge clk_i) begin
        if (rst_i || clear_i) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("r_hold_stable", 128'({r_valid_o, r_data_o, r_strb_o}), 128'(held));
            end
            hold_pend <= r_valid_o && !r_ready_i;
            held      <= {r_valid_o, r_data_o, r_strb_o};
            if (r_valid_o && r_ready_i) begin
                check("result_expected", 128'(exp_d.size() != 0), 128'(1));
                if (exp_d.size() != 0) begin
                    check("r_data", 128'(r_data_o), 128'(exp_d.pop_front()));
                    check("r_strb", 128'(r_strb_o), 128'(exp_s.pop_front()));
                end
            end
            if (a_valid_i && a_ready_o && b_valid_i && b_ready_o) fires <= fires + 1;
            if (a_ready_o || b_ready_o) ready_cycles <= ready_cycles + 1;
            if (done_o) begin
                dones       <= dones + 1;
                cnt_at_done <= cnt_o;
            end
        end
    end

    task automatic run_job(input alu_op_t op, input int len, input int gap, input int rr,
                           input int skew, input int stall_at, input int abort_at,
                           input bit use_clear, input bit restart, input bit chk_lat);
        int idx = 0;
        bit av = 1'b0;
        bit bv = 1'b0;
        bit hs, dn;
        bit seen_done = 1'b0;
        int f0, d0;
        int first_fire = -1;
        int first_rv = -1;
        exp_d.delete();
        exp_s.delete();
        for (int i = 0; i < len; i++) begin
            exp_d.push_back(ref_lanes(op, ja[i], jb[i]));
            exp_s.push_back(jsa[i] & jsb[i]);
        end
        f0 = fires;
        d0 = dones;
        start_i = 1'b1;
        op_i    = op;
        len_i   = LW'(len);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (idx < len) begin
                if (!av) av = ($urandom_range(99) >= gap);
                if (!bv) bv = (cyc >= skew) && ($urandom_range(99) >= gap);
            end
            a_valid_i = av;
            b_valid_i = bv;
            a_data_i  = ja[idx % 16];
            b_data_i  = jb[idx % 16];
            a_strb_i  = jsa[idx % 16];
            b_strb_i  = jsb[idx % 16];
            start_i   = restart && (cyc == 2);
            if (restart && cyc == 2) len_i = LW'(len + 3);
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) r_ready_i = 1'b0;
            else r_ready_i = ($urandom_range(99) < rr);
            @(negedge clk_i);
            if (cyc < skew) begin
                check("skew_a_ready", 128'(a_ready_o), 128'(0));
                check("skew_cnt", 128'(cnt_o), 128'(0));
            end
            if (stall_at >= 0 && cyc == stall_at + 4) begin
                check("stall_a_ready", 128'(a_ready_o), 128'(0));
            end
            hs = av && bv && a_ready_o && b_ready_o;
            if (hs && first_fire < 0) first_fire = cyc;
            if (r_valid_o && first_rv < 0) first_rv = cyc;
            dn = done_o;
            @(posedge clk_i); #1;
            if (hs) begin
                idx++;
                av = 1'b0;
                bv = 1'b0;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                a_valid_i = 1'b0;
                b_valid_i = 1'b0;
                if (use_clear) clear_i = 1'b1;
                else rst_i = 1'b1;
                if (!use_clear) begin
                    #1;
                    check("rst_outputs_zero", outs_vec(), 128'(0));
                end
                @(posedge clk_i); #1;
                check("abort_outputs_zero", outs_vec(), 128'(0));
                rst_i   = 1'b0;
                clear_i = 1'b0;
                exp_d.delete();
                exp_s.delete();
                repeat (3) @(posedge clk_i);
                #1;
                check("abort_no_done", 128'(dones - d0), 128'(0));
                check("abort_idle_busy", 128'(busy_o), 128'(0));
                return;
            end
            if (dn) begin
                seen_done = 1'b1;
                break;
            end
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        start_i   = 1'b0;
        check("done_seen", 128'(seen_done), 128'(1));
        check("fire_count", 128'(fires - f0), 128'(len));
        check("cnt_at_done", 128'(cnt_at_done), 128'(len));
        check("results_drained", 128'(exp_d.size()), 128'(0));
        if (chk_lat) check("first_result_latency", 128'(first_rv - first_fire), 128'(2));
        @(negedge clk_i);
        check("done_one_cycle", 128'(done_o), 128'(0));
        check("done_pulses", 128'(dones - d0), 128'(1));
        check("cnt_hold", 128'(cnt_o), 128'(len));
        check("busy_idle", 128'(busy_o), 128'(0));
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) begin
            ja[i]  = {rand_lane(), rand_lane()};
            jb[i]  = {rand_lane(), rand_lane()};
            jsa[i] = SW'($urandom);
            jsb[i] = SW'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_op_t op;
        int      r0, d0, len;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; op_i = ADD; len_i = '0;
        a_valid_i = 1'b0; a_data_i = '0; a_strb_i = '0;
        b_valid_i = 1'b0; b_data_i = '0; b_strb_i = '0;
        r_ready_i = 1'b0;
        #1;
        check("reset_outputs", outs_vec(), 128'(0));
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Directed ADD including lane wraparound, full-rate, with latency check.
        ja[0] = {32'd2, 32'd1};          jb[0] = {32'd4, 32'd3};
        ja[1] = {32'd5, 32'hFFFF_FFFF};  jb[1] = {32'd5, 32'd1};
        ja[2] = {32'd7, 32'd7};          jb[2] = {32'd1, 32'd1};
        for (int i = 0; i < 3; i++) begin jsa[i] = 8'hFF; jsb[i] = 8'hFF; end
        run_job(ADD, 3, 0, 100, 0, -1, -1, 1'b0, 1'b0, 1'b1);

        // SUB/MUL/MIN/MAX sign and overflow corners.
        for (int k = 1; k <= 4; k++) begin
            ja[0] = {2{32'h8000_0000}}; jb[0] = {2{32'd1}};
            jsa[0] = 8'hFF; jsb[0] = 8'hFF;
            run_job(alu_op_t'(3'(k)), 1, 0, 100, 0, -1, -1, 1'b0, 1'b0, 1'b0);
        end

        // A presented 4 cycles before B; strobes are ANDed.
        fill_random(1);
        jsa[0] = 8'hFF; jsb[0] = 8'h0F;
        run_job(MUL, 1, 0, 100, 4, -1, -1, 1'b0, 1'b0, 1'b0);

        // Five-cycle sink stall mid-job.
        fill_random(4);
        run_job(SUB, 4, 0, 100, 0, 1, -1, 1'b0, 1'b0, 1'b0);

        // Zero-length job: done next cycle, no readys even with valids up.
        r0 = ready_cycles; d0 = dones;
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        start_i = 1'b1; op_i = ADD; len_i = '0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("len0_done", 128'(done_o), 128'(1));
        check("len0_busy", 128'(busy_o), 128'(0));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("len0_done_drop", 128'(done_o), 128'(0));
        check("len0_no_ready", 128'(ready_cycles - r0), 128'(0));
        check("len0_one_pulse", 128'(dones - d0), 128'(1));
        a_valid_i = 1'b0; b_valid_i = 1'b0;

        // start_i during RUN is ignored.
        fill_random(3);
        run_job(MAX, 3, 20, 80, 0, -1, -1, 1'b0, 1'b1, 1'b0);

        // Reset mid-job after two beats, then a fresh single-beat job.
        fill_random(5);
        run_job(ADD, 5, 0, 50, 0, -1, 2, 1'b0, 1'b0, 1'b0);
        fill_random(1);
        run_job(MIN, 1, 0, 100, 0, -1, -1, 1'b0, 1'b0, 1'b0);

        // Same abort via synchronous clear.
        fill_random(4);
        run_job(MUL, 4, 0, 30, 0, -1, 1, 1'b1, 1'b0, 1'b0);
        fill_random(2);
        run_job(ADD, 2, 0, 100, 0, -1, -1, 1'b0, 1'b0, 1'b0);

        // Random jobs, including undefined op codes.
        for (int n = 0; n < 14; n++) begin
            op  = alu_op_t'(3'($urandom_range(7)));
            len = int'($urandom_range(10, 1));
            fill_random(len);
            run_job(op, len, int'($urandom_range(50)), int'($urandom_range(100, 40)),
                    0, -1, -1, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
